// File: rtl/ram_dma_pkg.sv
// Shared types for the RAM DMA initiator: FSM state encoding and command mode values.
package ram_dma_pkg;

   typedef enum logic [2:0] {
      IDLE,
      READ,
      WRITE,
      FILL,
      DONE
   } state_t;

   localparam logic MODE_COPY = 1'b0;
   localparam logic MODE_FILL = 1'b1;

endpackage

// File: rtl/ram_dma.sv
// Single-port RAM initiator: fills a region with a constant or memmoves one region to another.
// Owns the RAM port while busy; addresses wrap modulo the RAM depth.
module ram_dma
   import ram_dma_pkg::*;
#(
   parameter int DWIDTH = 16,
   parameter int AWIDTH = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              mode,
   input  logic [AWIDTH-1:0] src,
   input  logic [AWIDTH-1:0] dst,
   input  logic [AWIDTH:0]   count,
   input  logic [DWIDTH-1:0] fill_value,
   output logic              busy,
   output logic              done,
   output logic              ram_we,
   output logic [AWIDTH-1:0] ram_addr,
   output logic [DWIDTH-1:0] ram_wdata,
   input  logic [DWIDTH-1:0] ram_rdata
);

   state_t              state, state_next;
   logic [AWIDTH-1:0]   src_ptr, dst_ptr;
   logic [AWIDTH:0]     remaining;
   logic [DWIDTH-1:0]   hold, fill_q;
   logic                down;
   logic [AWIDTH-1:0]   last_addr;
   logic [DWIDTH-1:0]   last_wdata;

   // Copy must run backwards when the destination starts inside the source window.
   logic [AWIDTH-1:0]   diff;
   logic                start_down;
   assign diff       = dst - src;
   assign start_down = (mode == MODE_COPY) && (diff != '0) && ({1'b0, diff} < count);

   function automatic logic [AWIDTH-1:0] step(input logic [AWIDTH-1:0] p, input logic dec);
      return dec ? p - AWIDTH'(1) : p + AWIDTH'(1);
   endfunction

   // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
   always_comb begin
      state_next = state;
      busy       = 1'b0;
      done       = 1'b0;
      ram_we     = 1'b0;
      ram_addr   = last_addr;
      ram_wdata  = last_wdata;
      case (state)
         IDLE, DONE: begin
            done       = (state == DONE);
            state_next = IDLE;
            if (start) begin
               if (count == '0)
                  state_next = DONE;
               else if (mode == MODE_FILL)
                  state_next = FILL;
               else
                  state_next = READ;
            end
         end
         READ: begin
            busy       = 1'b1;
            ram_addr   = src_ptr;
            state_next = WRITE;
         end
         WRITE: begin
            busy       = 1'b1;
            ram_we     = 1'b1;
            ram_addr   = dst_ptr;
            ram_wdata  = hold;
            state_next = (remaining == (AWIDTH+1)'(1)) ? DONE : READ;
         end
         FILL: begin
            busy       = 1'b1;
            ram_we     = 1'b1;
            ram_addr   = dst_ptr;
            ram_wdata  = fill_q;
            state_next = (remaining == (AWIDTH+1)'(1)) ? DONE : FILL;
         end
         default: state_next = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         src_ptr    <= '0;
         dst_ptr    <= '0;
         remaining  <= '0;
         hold       <= '0;
         fill_q     <= '0;
         down       <= 1'b0;
         last_addr  <= '0;
         last_wdata <= '0;
      end else begin
         state      <= state_next;
         last_addr  <= ram_addr;
         last_wdata <= ram_wdata;
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  remaining <= count;
                  fill_q    <= fill_value;
                  down      <= start_down;
                  if (start_down) begin
                     src_ptr <= src + count[AWIDTH-1:0] - AWIDTH'(1);
                     dst_ptr <= dst + count[AWIDTH-1:0] - AWIDTH'(1);
                  end else begin
                     src_ptr <= src;
                     dst_ptr <= dst;
                  end
               end
            end
            READ: hold <= ram_rdata;
            WRITE: begin
               src_ptr   <= step(src_ptr, down);
               dst_ptr   <= step(dst_ptr, down);
               remaining <= remaining - (AWIDTH+1)'(1);
            end
            FILL: begin
               dst_ptr   <= step(dst_ptr, 1'b0);
               remaining <= remaining - (AWIDTH+1)'(1);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ram_dma.sv
// Self-checking bench for ram_dma: a behavioural RAM target, a write scoreboard and a reference memory image.
module tb_ram_dma;

   localparam int DW = 16;
   localparam int AW = 3;
   localparam int DEPTH = 1 << AW;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic          mode;
   logic [AW-1:0] src, dst;
   logic [AW:0]   count;
   logic [DW-1:0] fill_value;
   logic          busy, done, ram_we;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_wdata, ram_rdata;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } wr_t;

   logic [DW-1:0] mem     [DEPTH];
   logic [DW-1:0] ref_mem [DEPTH];
   wr_t           exp_q   [$];

   int checks = 0;
   int errors = 0;
   int we_cycles = 0;
   int done_cnt = 0;
   int wr_total = 0;

   always #5 clk = ~clk;

   ram_dma #(.DWIDTH(DW), .AWIDTH(AW)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .mode       (mode),
      .src        (src),
      .dst        (dst),
      .count      (count),
      .fill_value (fill_value),
      .busy       (busy),
      .done       (done),
      .ram_we     (ram_we),
      .ram_addr   (ram_addr),
      .ram_wdata  (ram_wdata),
      .ram_rdata  (ram_rdata)
   );

   // Combinational-read, synchronous-write RAM target.
   assign ram_rdata = mem[ram_addr];
   always @(posedge clk) if (ram_we) mem[ram_addr] <= ram_wdata;

   // Scoreboard: every RAM write must match the next expected write; done never overlaps busy.
   always @(negedge clk) begin
      if (ram_we) begin
         we_cycles++;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write addr=%0d data=%h", ram_addr, ram_wdata);
         end else begin
            wr_t e;
            e = exp_q.pop_front();
            if ({ram_addr, ram_wdata} !== {e.addr, e.data}) begin
               errors++;
               $display("FAIL write got addr=%0d data=%h expected addr=%0d data=%h",
                        ram_addr, ram_wdata, e.addr, e.data);
            end
            ref_mem[e.addr] = e.data;
            wr_total++;
         end
      end
      if (done) begin
         done_cnt++;
         checks++;
         if (busy !== 1'b0) begin
            errors++;
            $display("FAIL done_with_busy busy=%b expected 0", busy);
         end
      end
   end

   task automatic load_mem(input int base, input int stride);
      for (int i = 0; i < DEPTH; i++) begin
         mem[i]     = DW'(base + i * stride);
         ref_mem[i] = DW'(base + i * stride);
      end
   endtask

   task automatic check_mem(input string name);
      for (int i = 0; i < DEPTH; i++) begin
         checks++;
         if (mem[i] !== ref_mem[i]) begin
            errors++;
            $display("FAIL %s mem[%0d] got %h expected %h", name, i, mem[i], ref_mem[i]);
         end
      end
   endtask

   // Expected writes in issue order; data follows memmove semantics from the pre-command image.
   task automatic push_expected(input logic m, input logic [AW-1:0] s, input logic [AW-1:0] d,
                                input logic [AW:0] c, input logic [DW-1:0] fv);
      logic [DW-1:0] snap [DEPTH];
      logic [AW-1:0] dif;
      logic          dn;
      int            j;
      wr_t           w;
      for (int i = 0; i < DEPTH; i++) snap[i] = ref_mem[i];
      dif = d - s;
      dn  = (m == 1'b0) && (dif != '0) && ({1'b0, dif} < c);
      for (int i = 0; i < int'(c); i++) begin
         j      = dn ? int'(c) - 1 - i : i;
         w.addr = d + AW'(j);
         w.data = m ? fv : snap[s + AW'(j)];
         exp_q.push_back(w);
      end
   endtask

   // Called at a negedge; returns #1 after the accepting edge.
   task automatic issue_start(input logic m, input logic [AW-1:0] s, input logic [AW-1:0] d,
                              input logic [AW:0] c, input logic [DW-1:0] fv);
      push_expected(m, s, d, c, fv);
      mode = m; src = s; dst = d; count = c; fill_value = fv;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   // lat = cycles after k+1 until done; returns at the negedge of the done cycle.
   task automatic wait_done(input int exp_lat, input string name);
      int lat = 0;
      @(negedge clk);
      checks++;
      if (busy !== (exp_lat > 0)) begin
         errors++;
         $display("FAIL %s_busy_first got %b expected %b", name, busy, exp_lat > 0);
      end
      while (!done && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      checks++;
      if (lat !== exp_lat) begin
         errors++;
         $display("FAIL %s_done_latency got %0d expected %0d", name, lat, exp_lat);
      end
   endtask

   task automatic check_queue_empty(input string name);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL %s_pending_writes got %0d expected 0", name, exp_q.size());
      end
      exp_q.delete();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      checks++;
      if ({busy, done, ram_we, ram_addr, ram_wdata} !== '0) begin
         errors++;
         $display("FAIL reset_outputs got busy=%b done=%b we=%b addr=%0d wdata=%h expected all 0",
                  busy, done, ram_we, ram_addr, ram_wdata);
      end
   endtask

   task automatic test_fill();
      load_mem(0, 0);
      we_cycles = 0;
      issue_start(1'b1, 3'd0, 3'd6, 4'd4, 16'hA5A5);
      wait_done(4, "fill");
      @(negedge clk);
      checks++;
      if (we_cycles !== 4) begin
         errors++;
         $display("FAIL fill_we_cycles got %0d expected 4", we_cycles);
      end
      check_queue_empty("fill");
      check_mem("fill");
   endtask

   task automatic test_forward_copy();
      load_mem(16'h100, 1);
      issue_start(1'b0, 3'd0, 3'd4, 4'd4, 16'h0);
      wait_done(8, "fwd_copy");
      @(negedge clk);
      check_queue_empty("fwd_copy");
      check_mem("fwd_copy");
   endtask

   task automatic test_overlap_copy();
      load_mem(0, 1);
      issue_start(1'b0, 3'd1, 3'd3, 4'd4, 16'h0);
      wait_done(8, "overlap");
      @(negedge clk);
      check_queue_empty("overlap");
      check_mem("overlap");
      // Same-address copy and a wrapping forward copy.
      issue_start(1'b0, 3'd5, 3'd5, 4'd2, 16'h0);
      wait_done(4, "same_addr");
      @(negedge clk);
      issue_start(1'b0, 3'd6, 3'd1, 4'd3, 16'h0);
      wait_done(6, "wrap_copy");
      @(negedge clk);
      check_queue_empty("wrap_copy");
      check_mem("wrap_copy");
   endtask

   task automatic test_count_zero_busy_ignore();
      load_mem(16'h3000, 3);
      we_cycles = 0;
      done_cnt  = 0;
      issue_start(1'b1, 3'd0, 3'd2, 5'd0, 16'hFFFF);
      wait_done(0, "count0");
      @(negedge clk);
      checks++;
      if (we_cycles !== 0) begin
         errors++;
         $display("FAIL count0_writes got %0d expected 0", we_cycles);
      end
      done_cnt = 0;
      issue_start(1'b1, 3'd0, 3'd3, 4'd8, 16'h5A5A);
      fork
         begin
            repeat (2) @(negedge clk);
            mode = 1'b0; src = 3'd7; dst = 3'd1; count = 4'd2; fill_value = 16'h1234;
            start = 1'b1;
            @(posedge clk);
            #1 start = 1'b0;
         end
      join_none
      wait_done(8, "fill8");
      repeat (4) @(negedge clk);
      checks++;
      if (done_cnt !== 1) begin
         errors++;
         $display("FAIL busy_ignore_done_count got %0d expected 1", done_cnt);
      end
      check_queue_empty("fill8");
      check_mem("fill8");
   endtask

   task automatic test_reset_mid_copy();
      int budget = 0;
      load_mem(16'h40, 16'h11);
      issue_start(1'b0, 3'd0, 3'd2, 4'd8, 16'h0);
      wr_total = 0;
      while (wr_total < 3 && budget < 50) begin
         @(negedge clk);
         budget++;
      end
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      checks++;
      if ({ram_we, busy, done} !== 3'b000) begin
         errors++;
         $display("FAIL reset_mid_copy got we=%b busy=%b done=%b expected 000", ram_we, busy, done);
      end
      checks++;
      if (exp_q.size() != 5) begin
         errors++;
         $display("FAIL reset_mid_copy_remaining got %0d expected 5", exp_q.size());
      end
      exp_q.delete();
      check_mem("reset_mid_copy");
      issue_start(1'b1, 3'd4, 3'd4, 4'd3, 16'hBEEF);
      wait_done(3, "post_reset_fill");
      @(negedge clk);
      check_queue_empty("post_reset_fill");
      check_mem("post_reset_fill");
   endtask

   task automatic test_back_to_back();
      load_mem(16'h7700, 1);
      done_cnt = 0;
      issue_start(1'b1, 3'd0, 3'd2, 4'd3, 16'h1111);
      wait_done(3, "b2b_fill");
      issue_start(1'b0, 3'd2, 3'd5, 4'd3, 16'h0);
      wait_done(6, "b2b_copy");
      repeat (2) @(negedge clk);
      checks++;
      if (done_cnt !== 2) begin
         errors++;
         $display("FAIL b2b_done_count got %0d expected 2", done_cnt);
      end
      check_queue_empty("b2b");
      check_mem("b2b");
   endtask

   initial begin
      start = 1'b0; mode = 1'b0; src = '0; dst = '0; count = '0; fill_value = '0;
      load_mem(0, 0);
      test_reset();
      test_fill();
      test_forward_copy();
      test_overlap_copy();
      test_count_zero_busy_ignore();
      test_reset_mid_copy();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ram_dma.md
# ram_dma

Single-port RAM initiator: drives the we/addr/wdata/rdata interface of the team's combinational-read RAM to fill a region with a constant or copy one region to another (memmove semantics, overlap-safe, addresses wrap modulo 2^AWIDTH). It sits between the CPU's control logic and a scratch RAM instance and owns the RAM port while busy. Command is a one-cycle start pulse; completion is a one-cycle done pulse.

## Interface
- DWIDTH, 16, RAM data width
- AWIDTH, 3, RAM address width; RAM depth 2**AWIDTH
- clk  in  1  sole clock; all state changes on posedge clk
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high
- start  in  1  command strobe; sampled only when busy=0
- mode  in  1  0=copy, 1=fill; sampled with start
- src  in  AWIDTH  copy source base address (ignored for fill)
- dst  in  AWIDTH  destination base address
- count  in  AWIDTH+1  words to transfer, 0..2**AWIDTH
- fill_value  in  DWIDTH  data written in fill mode
- busy  out  1  high while transfer in progress
- done  out  1  one-cycle pulse when transfer completes
- ram_we  out  1  RAM write enable
- ram_addr  out  AWIDTH  RAM address
- ram_wdata  out  DWIDTH  RAM write data
- ram_rdata  in  DWIDTH  RAM read data, combinational from ram_addr

## Operation
- States: IDLE, READ, WRITE, FILL, DONE. busy=1 in READ/WRITE/FILL; done=1 only in DONE.
- IDLE or DONE, start=1: latch mode/src/dst/count/fill_value. count=0 -> DONE. Else mode=1 -> FILL, mode=0 -> READ.
- Direction (copy only): descending iff (dst-src) mod 2**AWIDTH is nonzero and < count; then pointers start at src+count-1, dst+count-1 and decrement. Otherwise ascending from src, dst. Fill always ascending.
- READ: ram_addr=src pointer, ram_we=0; hold register captures ram_rdata at cycle end -> WRITE.
- WRITE: ram_addr=dst pointer, ram_we=1, ram_wdata=hold; step both pointers, decrement remaining; remaining reaches 0 -> DONE, else READ.
- FILL: ram_addr=dst pointer, ram_we=1, ram_wdata=fill_value; step pointer, decrement; remaining reaches 0 -> DONE.
- DONE: one cycle -> IDLE (or straight into new command if start=1).
- Pointer arithmetic AWIDTH bits, wraps silently (7+1=0, 0-1=7 for AWIDTH=3). remaining is AWIDTH+1 bits, never underflows.
- start while busy=1: ignored, no effect on latched operands.
- src==dst copy: performed normally (read then write same word).
- IDLE/DONE: ram_we=0, ram_addr and ram_wdata hold last value.

## Timing
- Reset values: busy=0, done=0, ram_we=0, ram_addr=0, ram_wdata=0, state IDLE, hold=0.
- start high at edge k -> busy=1 from cycle k+1 (count>0).
- Copy of N words: busy for 2N cycles; first write in cycle k+2; done in cycle k+2N+1.
- Fill of N words: busy for N cycles; first write in cycle k+1; done in cycle k+N+1.
- count=0: done in cycle k+1, busy never asserted, no RAM write.
- All outputs derived from registered state only; no combinational path from start/src/dst/count/mode to any output.
- reset mid-transfer: at next edge state IDLE, ram_we=0, done not pulsed; words already written stay written.
- Back-to-back: start during DONE accepted; done and new busy do not overlap.

## Structure
- Shared package ram_dma_pkg: state enum (IDLE, READ, WRITE, FILL, DONE), MODE_COPY=0 / MODE_FILL=1 constants.
- No sub-module; single FSM plus pointer/counter datapath. Bench instantiates the existing RAM module (same DWIDTH/AWIDTH) as the target.

## Test plan
- Fill: AWIDTH=3, RAM zeroed, start fill dst=6 count=4 fill_value=16'hA5A5 -> words 6,7,0,1 = A5A5, others 0; done at k+5; ram_we high exactly 4 cycles.
- Forward copy: RAM[i]=i+16'h100, copy src=0 dst=4 count=4 -> RAM[4..7]=0x100..0x103, RAM[0..3] unchanged; done at k+9.
- Overlap memmove: RAM[i]=i, copy src=1 dst=3 count=4 (descending) -> RAM[3..6]=1,2,3,4, RAM[0..2]=0,1,2, RAM[7]=7.
- count=0 and busy-ignore: start count=0 -> done at k+1, no writes; then start fill count=8, pulse start again at cycle 3 -> second start ignored, all 8 words filled once, single done.
- Reset mid-copy: copy count=8, assert reset for 1 cycle after third write -> ram_we=0, busy=0, done=0 next cycle; only first 3 destination words changed; subsequent fill command works normally.
- Back-to-back: start during DONE cycle of a fill -> second command begins next cycle, done pulses twice, never concurrent with busy.
